// File: rtl/diy_mole_recorder_if.sv
// Pad/music-side inputs and table-side outputs of the DIY mole recorder.
interface diy_mole_recorder_if;
   localparam int unsigned AW    = 23;
   localparam int unsigned SLOTS = 16;
   localparam int unsigned CW    = 5;

   logic                  record_start;
   logic                  diy_mode;
   logic                  stomp;
   logic [AW-1:0]         music_address;
   logic [SLOTS*AW-1:0]   recorded_addresses;
   logic [CW-1:0]         entry_count;
   logic                  recording;
   logic                  table_valid;
   logic                  ready_to_use;
   logic                  rejected;

   modport master (
      output record_start, diy_mode, stomp, music_address,
      input  recorded_addresses, entry_count, recording, table_valid, ready_to_use, rejected
   );

   modport slave (
      input  record_start, diy_mode, stomp, music_address,
      output recorded_addresses, entry_count, recording, table_valid, ready_to_use, rejected
   );
endinterface

// File: rtl/diy_mole_recorder.sv
// Records stomp-timed music addresses into a 16-entry table that the mole
// timing logic replays in DIY mode.
module diy_mole_recorder #(
   parameter logic [22:0] MIN_GAP     = 23'h2000,
   parameter logic [22:0] END_ADDRESS = 23'h4FFFF,
   parameter logic [22:0] FILL        = 23'h7FFFFF
) (
   input  logic               clk,
   input  logic               reset,
   diy_mole_recorder_if.slave bus
);
   localparam int unsigned AW    = 23;
   localparam int unsigned SLOTS = 16;
   localparam int unsigned CW    = 5;
   localparam int unsigned IW    = 4;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RECORDING = 2'd1,
      DONE      = 2'd2
   } state_t;

   state_t                   state_q;
   state_t                   state_d;
   logic [0:SLOTS-1][AW-1:0] slots_q;
   logic [0:SLOTS-1][AW-1:0] slots_d;
   logic [CW-1:0]            count_q;
   logic [CW-1:0]            count_d;
   logic                     stomp_d;
   logic                     recording_q;
   logic                     table_valid_q;
   logic                     ready_q;
   logic                     rejected_q;
   logic                     rejected_d;

   logic                     in_rec_c;
   logic                     start_c;
   logic                     stomp_edge_c;
   logic                     accept_c;
   logic                     write_c;
   logic                     end_hit_c;
   logic                     clear_c;
   logic [CW-1:0]            count_inc_c;
   logic [AW-1:0]            last_c;
   logic [AW:0]              limit_c;

   // Shared decode; the gap check is done in AW+1 bits so last+MIN_GAP cannot wrap.
   assign in_rec_c     = (state_q == RECORDING);
   assign start_c      = bus.record_start & bus.diy_mode;
   assign stomp_edge_c = bus.stomp & ~stomp_d;
   assign last_c       = slots_q[IW'(count_q - CW'(1))];
   assign limit_c      = {1'b0, last_c} + {1'b0, MIN_GAP};
   assign accept_c     = (count_q == '0) || ({1'b0, bus.music_address} >= limit_c);
   assign write_c      = in_rec_c & bus.diy_mode & stomp_edge_c & accept_c;
   assign count_inc_c  = count_q + CW'(write_c);
   assign end_hit_c    = (count_inc_c == CW'(SLOTS)) || (bus.music_address >= END_ADDRESS);
   assign clear_c      = (!in_rec_c && start_c) || (in_rec_c && !bus.diy_mode);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start_c) state_d = RECORDING;
         end
         RECORDING: begin
            if (!bus.diy_mode) begin
               state_d = IDLE;
            end else if (end_hit_c) begin
               state_d = (count_inc_c != '0) ? DONE : IDLE;
            end
         end
         DONE: begin
            if (start_c) state_d = RECORDING;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      slots_d    = slots_q;
      count_d    = count_q;
      rejected_d = 1'b0;
      if (clear_c) begin
         slots_d = {SLOTS{FILL}};
         count_d = '0;
      end else if (write_c) begin
         slots_d[count_q[IW-1:0]] = bus.music_address;
         count_d                  = count_inc_c;
      end else if (in_rec_c && bus.diy_mode && stomp_edge_c) begin
         rejected_d = 1'b1;
      end
   end

   // Table, counter, edge flop and status flags; status follows the next state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slots_q       <= {SLOTS{FILL}};
         count_q       <= '0;
         stomp_d       <= 1'b0;
         recording_q   <= 1'b0;
         table_valid_q <= 1'b0;
         ready_q       <= 1'b0;
         rejected_q    <= 1'b0;
      end else begin
         slots_q       <= slots_d;
         count_q       <= count_d;
         stomp_d       <= bus.stomp;
         recording_q   <= (state_d == RECORDING);
         table_valid_q <= (state_d == DONE);
         ready_q       <= (state_d == DONE) && (state_q != DONE);
         rejected_q    <= rejected_d;
      end
   end

   assign bus.recorded_addresses = slots_q;
   assign bus.entry_count        = count_q;
   assign bus.recording          = recording_q;
   assign bus.table_valid        = table_valid_q;
   assign bus.ready_to_use       = ready_q;
   assign bus.rejected           = rejected_q;

endmodule

// File: tb/tb_diy_mole_recorder.sv
// Self-checking bench for diy_mole_recorder: vector table, corner sequences
// and randomized traffic against a queue-based model of the recording rules.
module tb_diy_mole_recorder;
   localparam logic [22:0] FILL    = 23'h7FFFFF;
   localparam int unsigned MIN_GAP = 'h2000;
   localparam int unsigned END_A   = 'h4FFFF;
   localparam int MODE_IDLE = 0;
   localparam int MODE_REC  = 1;
   localparam int MODE_DONE = 2;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   diy_mole_recorder_if bus ();

   diy_mole_recorder dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model state: the take is a queue of accepted addresses.
   logic [22:0] mq[$];
   int          m_mode;
   bit          m_prev;
   bit          m_ready;
   bit          m_rej;

   typedef struct {
      bit          st;
      bit          dy;
      bit          sp;
      logic [22:0] a;
      logic [4:0]  cnt;
      bit          rec;
      bit          valid;
      bit          ready;
      bit          rej;
   } vec_t;

   task automatic check(input string nm, input logic [367:0] act, input logic [367:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s act=%0h req=%0h", nm, act, req);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_mode  = MODE_IDLE;
      m_prev  = 1'b0;
      m_ready = 1'b0;
      m_rej   = 1'b0;
   endtask

   task automatic model_step(input bit st, input bit dy, input bit sp, input logic [22:0] a);
      bit rise;
      rise    = sp && !m_prev;
      m_prev  = sp;
      m_ready = 1'b0;
      m_rej   = 1'b0;
      if (m_mode == MODE_REC) begin
         if (!dy) begin
            mq.delete();
            m_mode = MODE_IDLE;
         end else begin
            if (rise) begin
               if (mq.size() == 0 || int'({9'd0, a}) >= int'({9'd0, mq[$]}) + int'(MIN_GAP))
                  mq.push_back(a);
               else
                  m_rej = 1'b1;
            end
            if (mq.size() == 16 || int'({9'd0, a}) >= int'(END_A)) begin
               if (mq.size() > 0) begin
                  m_mode  = MODE_DONE;
                  m_ready = 1'b1;
               end else begin
                  m_mode = MODE_IDLE;
               end
            end
         end
      end else if (st && dy) begin
         mq.delete();
         m_mode = MODE_REC;
      end
   endtask

   task automatic compare_model();
      logic [0:15][22:0] et;
      for (int i = 0; i < 16; i++) et[i] = (i < mq.size()) ? mq[i] : FILL;
      check("m_table", bus.recorded_addresses, et);
      check("m_count", 368'(bus.entry_count), 368'(mq.size()));
      check("m_recording", 368'(bus.recording), 368'(m_mode == MODE_REC));
      check("m_table_valid", 368'(bus.table_valid), 368'(m_mode == MODE_DONE));
      check("m_ready", 368'(bus.ready_to_use), 368'(m_ready));
      check("m_rejected", 368'(bus.rejected), 368'(m_rej));
   endtask

   // One clock: drive inputs away from the edge, advance model, compare after edge.
   task automatic cycle(input bit st, input bit dy, input bit sp, input logic [22:0] a);
      bus.record_start  = st;
      bus.diy_mode      = dy;
      bus.stomp         = sp;
      bus.music_address = a;
      model_step(st, dy, sp, a);
      @(posedge clk);
      #1;
      compare_model();
   endtask

   task automatic do_reset();
      bus.record_start  = 1'b0;
      bus.stomp         = 1'b0;
      bus.music_address = '0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic check_cleared(input string nm);
      check({nm, "_table"}, bus.recorded_addresses, {16{FILL}});
      check({nm, "_count"}, 368'(bus.entry_count), 368'(0));
      check({nm, "_flags"}, 368'({bus.recording, bus.table_valid, bus.ready_to_use, bus.rejected}), 368'(0));
   endtask

   vec_t        vecs[13];
   bit          sp;
   bit          st;
   bit          dy;
   logic [22:0] addr;
   int unsigned r;

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      bus.record_start  = 1'b0;
      bus.diy_mode      = 1'b0;
      bus.stomp         = 1'b0;
      bus.music_address = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_cleared("reset");
      reset = 1'b0;

      // Basic take with a spacing reject, held stomp and DONE behaviour.
      vecs[0]  = '{1, 1, 0, 23'h00000, 5'd0, 1, 0, 0, 0};
      vecs[1]  = '{0, 1, 1, 23'h01000, 5'd1, 1, 0, 0, 0};
      vecs[2]  = '{0, 1, 0, 23'h01800, 5'd1, 1, 0, 0, 0};
      vecs[3]  = '{0, 1, 1, 23'h05000, 5'd2, 1, 0, 0, 0};
      vecs[4]  = '{0, 1, 0, 23'h05400, 5'd2, 1, 0, 0, 0};
      vecs[5]  = '{0, 1, 1, 23'h05800, 5'd2, 1, 0, 0, 1};
      vecs[6]  = '{0, 1, 1, 23'h09000, 5'd2, 1, 0, 0, 0};
      vecs[7]  = '{0, 1, 0, 23'h09000, 5'd2, 1, 0, 0, 0};
      vecs[8]  = '{0, 1, 1, 23'h09000, 5'd3, 1, 0, 0, 0};
      vecs[9]  = '{0, 1, 0, 23'h4FFFF, 5'd3, 0, 1, 1, 0};
      vecs[10] = '{0, 1, 0, 23'h50000, 5'd3, 0, 1, 0, 0};
      vecs[11] = '{0, 1, 1, 23'h60000, 5'd3, 0, 1, 0, 0};
      vecs[12] = '{0, 0, 0, 23'h60000, 5'd3, 0, 1, 0, 0};
      for (int i = 0; i < 13; i++) begin
         cycle(vecs[i].st, vecs[i].dy, vecs[i].sp, vecs[i].a);
         check($sformatf("v%0d_count", i), 368'(bus.entry_count), 368'(vecs[i].cnt));
         check($sformatf("v%0d_flags", i),
               368'({bus.recording, bus.table_valid, bus.ready_to_use, bus.rejected}),
               368'({vecs[i].rec, vecs[i].valid, vecs[i].ready, vecs[i].rej}));
      end
      check("take_head", 368'(bus.recorded_addresses[367:299]), 368'({23'h01000, 23'h05000, 23'h09000}));
      check("take_tail", 368'(bus.recorded_addresses[298:0]), 368'({13{FILL}}));

      // Spacing.
      do_reset();
      cycle(1, 1, 0, 23'h0);
      cycle(0, 1, 1, 23'h3000);
      cycle(0, 1, 0, 23'h3000);
      cycle(0, 1, 1, 23'h3800);
      check("gap_rejected", 368'(bus.rejected), 368'(1));
      cycle(0, 1, 0, 23'h3800);
      cycle(0, 1, 1, 23'h5000);
      check("gap_count", 368'(bus.entry_count), 368'(2));
      check("gap_slots", 368'(bus.recorded_addresses[367:322]), 368'({23'h3000, 23'h5000}));

      // Full table: 17 stomps 0x2000 apart.
      do_reset();
      cycle(1, 1, 0, 23'h0);
      for (int k = 0; k < 17; k++) begin
         cycle(0, 1, 1, 23'(k * 'h2000));
         if (k == 15) begin
            check("full_count16", 368'(bus.entry_count), 368'(16));
            check("full_done", 368'({bus.recording, bus.table_valid, bus.ready_to_use}), 368'(3'b011));
         end
         cycle(0, 1, 0, 23'(k * 'h2000));
      end
      check("full_count_stays", 368'(bus.entry_count), 368'(16));
      check("full_slot15", 368'(bus.recorded_addresses[22:0]), 368'(23'h1E000));

      // Abort, with diy_mode dropping on a stomp edge.
      do_reset();
      cycle(1, 1, 0, 23'h0);
      cycle(0, 1, 1, 23'h1000);
      cycle(0, 1, 0, 23'h2000);
      cycle(0, 1, 1, 23'h4000);
      cycle(0, 1, 0, 23'h7000);
      check("abort_pre_count", 368'(bus.entry_count), 368'(2));
      cycle(0, 0, 1, 23'h8000);
      check_cleared("abort");
      cycle(0, 0, 0, 23'h8100);
      check_cleared("abort_after");

      // Held stomp yields one entry, then async reset between edges.
      do_reset();
      cycle(1, 1, 0, 23'h0);
      for (int k = 0; k < 1000; k++) cycle(0, 1, 1, 23'(32'h100 + k));
      check("held_count", 368'(bus.entry_count), 368'(1));
      check("held_slot0", 368'(bus.recorded_addresses[367:345]), 368'(23'h100));
      #2 reset = 1'b1;
      #1;
      check_cleared("async_reset");
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      cycle(1, 1, 1, 23'h1000);
      cycle(0, 1, 0, 23'h1000);
      cycle(0, 1, 1, 23'h2000);
      check("restart_slot0", 368'(bus.recorded_addresses[367:345]), 368'(23'h2000));
      check("restart_count", 368'(bus.entry_count), 368'(1));

      // End address with no entries returns to IDLE.
      do_reset();
      cycle(1, 1, 0, 23'h0);
      cycle(0, 1, 0, 23'h4FFFF);
      check_cleared("empty_end");
      cycle(0, 1, 0, 23'h50000);
      check_cleared("empty_end_after");

      // Randomized traffic against the model.
      do_reset();
      sp   = 1'b0;
      addr = '0;
      for (int n = 0; n < 4000; n++) begin
         st = ($urandom_range(0, 29) == 0);
         dy = ($urandom_range(0, 59) != 0);
         if ($urandom_range(0, 2) == 0) sp = ~sp;
         r = $urandom_range(0, 99);
         if (r < 2)      addr = '0;
         else if (r < 4) addr = addr + 23'h8000;
         else            addr = addr + 23'($urandom_range(0, 'h900));
         if (addr > 23'h52000) addr = '0;
         cycle(st, dy, sp, addr);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/diy_mole_recorder.md
# diy_mole_recorder

Records player-timed mole pop-up points during DIY mode and exports them as a packed address table for the mole timing logic. While recording, each new stomp latches the current music sample address into the next table slot. The block sits between the debounced pad inputs and music address counter on one side, and the game state FSM and mole timing block on the other. It is the writer of the 16-entry, 23-bit address table that the mole block compares against `music_address`.

## Interface
- `MIN_GAP`, 23'h2000: minimum address spacing between consecutive accepted entries.
- `END_ADDRESS`, 23'h4FFFF: music address at or beyond which recording closes automatically.
- `FILL`, 23'h7FFFFF: value held in unused slots; it never matches a real music address.
- `clk`  in  1  system clock (27 MHz).
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `record_start`  in  1  one-cycle pulse; the game FSM asserts it on entry to RECORD_DIY_BEGIN.
- `diy_mode`  in  1  level; DIY switch.
- `stomp`  in  1  level; OR of the eight debounced pads.
- `music_address`  in  23  current playback sample address.
- `recorded_addresses`  out  368  packed table; entry 0 at [367:345], entry k at [367-23k -: 23].
- `entry_count`  out  5  number of accepted entries, 0..16.
- `recording`  out  1  high while in RECORDING.
- `table_valid`  out  1  high while in DONE.
- `ready_to_use`  out  1  one-cycle pulse on entry to DONE.
- `rejected`  out  1  one-cycle pulse when a stomp edge is discarded.

## Operation
- States: IDLE, RECORDING, DONE. Reset value is IDLE.
- Reset values:
  - All slots = FILL.
  - `entry_count` = 0.
  - `recording`, `table_valid`, `ready_to_use`, `rejected` = 0.
  - Edge-detect flop = 0.
- Stomp edge detection: registered `stomp_d`; `edge = stomp & ~stomp_d`. This is evaluated in every state, but it only acts in RECORDING.
- IDLE:
  - If `record_start & diy_mode`: fill all slots with FILL, set count to 0, go to RECORDING.
  - Otherwise stay in IDLE.
- RECORDING, evaluated in priority order each cycle:
  1. If `!diy_mode`, abort: fill all slots with FILL, set count to 0, go to IDLE. No `ready_to_use`.
  2. If `edge`:
     - Accept when `count == 0`, or when `music_address >= last + MIN_GAP`. `last` is slot count-1. Compute the comparison in 24 bits so that `last + MIN_GAP` cannot wrap.
     - On accept: write `music_address` to slot `count`, then increment count.
     - On non-accept, including an address lower than `last` (music wrap): pulse `rejected` and leave the table unchanged.
  3. Exit after any write from step 2:
     - If count after the write is 16, or `music_address >= END_ADDRESS`, go to DONE if count is at least 1, otherwise go to IDLE.
- DONE:
  - Table and count are frozen; stomps are ignored.
  - `record_start & diy_mode` clears the table and goes to RECORDING.
  - `diy_mode` falling does not clear the table; the table persists for DIY playback.
- `record_start` in RECORDING is ignored. Recording never restarts mid-take.

## Timing
- All outputs are registered and change on the `clk` edge; `reset` is the only asynchronous path.
- Capture latency:
  - A stomp rising at input edge N is seen as `edge` in the cycle after edge N.
  - The slot write and count increment land on edge N+1.
  - `recorded_addresses` reflects the write from edge N+1.
- `rejected` is high for exactly the one cycle following the rejecting edge.
- The 16th accept, or an accept at or beyond END_ADDRESS:
  - The write and the transition to DONE happen on the same edge.
  - `ready_to_use` and `table_valid` rise in the following cycle.
  - `ready_to_use` falls one cycle later.
- A stomp held high produces exactly one capture; the next capture requires a low cycle followed by a new rise.
- Simultaneous edge and `!diy_mode`: the abort wins and nothing is written.
- Simultaneous edge and END_ADDRESS: an accepted capture is written first, then the block enters DONE.
- Reset mid-RECORDING: outputs return to reset values without waiting for a clock edge. The next `record_start` begins cleanly.

## Test plan
- Basic take:
  - Stimulus: `record_start` with `diy_mode`=1, then stomps at addresses 0x1000, 0x5000, 0x9000, then `music_address` reaches 0x4FFFF.
  - Required: `entry_count`=3, `recorded_addresses[367:299]` = {0x1000, 0x5000, 0x9000}, remaining slots 0x7FFFFF, one `ready_to_use` pulse, `table_valid`=1.
- Spacing:
  - Stimulus: stomps at 0x3000, 0x3800, 0x5000.
  - Required: the 0x3800 stomp pulses `rejected`; the table holds 0x3000 and 0x5000; count=2.
- Full table:
  - Stimulus: 17 stomps spaced 0x2000 apart, starting at 0x0.
  - Required: count stops at 16, DONE is entered on the 16th write, the 17th stomp is ignored, slot 15 = 0x1E000.
- Abort:
  - Stimulus: two accepted stomps, then `diy_mode` goes 0, including a cycle where `diy_mode`=0 coincides with a stomp edge.
  - Required: state IDLE, count=0, all slots 0x7FFFFF, no `ready_to_use`.
- Held stomp and reset:
  - Stimulus: `stomp` held high for 1000 cycles, giving one entry; then `reset` is asserted asynchronously mid-RECORDING between clock edges.
  - Required: outputs clear immediately, and a subsequent `record_start` records from slot 0.
- End with no entries:
  - Stimulus: `music_address` reaches END_ADDRESS with no stomps recorded.
  - Required: the block returns to IDLE, `ready_to_use` stays 0, `table_valid` stays 0.
